// File: rtl/rsa_pack_prep.sv
// -----------------------------------------------------------------------------
// rsa_pack_prep
//
// Pre-processing stage in front of the Montgomery exponentiator. Accepts one
// {msg, key, modulus} request and computes base = 2^(2*MOD_WIDTH) mod modulus.
// Each step doubles x and conditionally subtracts the modulus. The
// {base, msg, key, modulus} bundle is then presented on a valid/ready output.
// Only one request is in flight at a time.
//
// Parameters
//   MOD_WIDTH  key/modulus width in bits (default 256)
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   i_valid  in   request valid
//   i_ready  out  stage idle, can accept a request
//   i_in     in   {msg, key, modulus}, msg in the MSBs
//   o_valid  out  result bundle valid
//   o_ready  in   downstream accepts the bundle
//   o_out    out  {base, msg, key, modulus}, base in the MSBs
//   o_err    out  modulus rejected (meaningful only while o_valid)
//
// Build option
//   RSA_PREP_MOD_CHECK_EN  reject even moduli and moduli < 3 at accept. A
//                          rejected request is reported one cycle later with
//                          base = 0 and o_err = 1. When undefined, o_err is 0
//                          and every request runs the full computation.
// -----------------------------------------------------------------------------
module rsa_pack_prep #(
    parameter int MOD_WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [3*MOD_WIDTH-1:0] i_in,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [4*MOD_WIDTH-1:0] o_out,
    output logic                   o_err
);

    localparam int CNT_W = $clog2(2*MOD_WIDTH+1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*MOD_WIDTH-1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [MOD_WIDTH-1:0] msg_q, msg_d;
    logic [MOD_WIDTH-1:0] key_q, key_d;
    logic [MOD_WIDTH-1:0] mod_q, mod_d;
    logic [MOD_WIDTH-1:0] x_q, x_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [MOD_WIDTH:0]   t;
    logic [MOD_WIDTH-1:0] diff;
    logic [MOD_WIDTH-1:0] in_mod;

`ifdef RSA_PREP_MOD_CHECK_EN
    logic err_q, err_d;
`endif

    assign in_mod = i_in[MOD_WIDTH-1:0];
    assign t      = {x_q, 1'b0};
    // Low bits of (t - modulus) only depend on the low bits of t.
    assign diff   = t[MOD_WIDTH-1:0] - mod_q;

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        key_d   = key_q;
        mod_d   = mod_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
`ifdef RSA_PREP_MOD_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    msg_d   = i_in[3*MOD_WIDTH-1:2*MOD_WIDTH];
                    key_d   = i_in[2*MOD_WIDTH-1:MOD_WIDTH];
                    mod_d   = in_mod;
                    // Start from 1 mod N so that N == 1 reduces to base 0;
                    // plain doubling would otherwise keep x stuck at 1.
                    x_d     = (in_mod == MOD_WIDTH'(1)) ? '0 : MOD_WIDTH'(1);
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef RSA_PREP_MOD_CHECK_EN
                    err_d   = ~in_mod[0] || (in_mod < MOD_WIDTH'(3));
`endif
                end
            end
            CALC: begin
                x_d   = (t >= {1'b0, mod_q}) ? diff : t[MOD_WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = OUT;
`ifdef RSA_PREP_MOD_CHECK_EN
                if (err_q) begin
                    x_d     = '0;
                    state_d = OUT;
                end
`endif
            end
            OUT: begin
                if (o_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            msg_q   <= '0;
            key_q   <= '0;
            mod_q   <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
`ifdef RSA_PREP_MOD_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            key_q   <= key_d;
            mod_q   <= mod_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
`ifdef RSA_PREP_MOD_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign i_ready = (state_q == IDLE);
    assign o_valid = (state_q == OUT);
    assign o_out   = {x_q, msg_q, key_q, mod_q};
`ifdef RSA_PREP_MOD_CHECK_EN
    assign o_err   = err_q;
`else
    assign o_err   = 1'b0;
`endif

endmodule
